fft4_seq_ctrl: RTL and testbench

- Sequencer that computes one 4-point DIT FFT frame by time-sharing a single combinational radix-2 butterfly over four cycles.
- Accepts 4 packed complex samples on a valid/ready stream and stores them in a 4-entry in-place register file.
- Drives the external butterfly's A/B/W inputs and captures out0/out1 back into the register file.
- Streams X0..X3 out in natural order; sits between the sample source and the downstream consumer in the FFT top level.

---
 rtl/fft4_pkg.sv | 47 ++++
 rtl/fft4_twiddle_sel.sv | 38 +++
 rtl/fft4_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_fft4_seq_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft4_pkg.sv
// Shared types, complex helpers and twiddle constants for the 4-point FFT sequencer.
// Optional inverse transform support is enabled by defining FFT4_INV_EN.
package fft4_pkg;

    localparam int FFT4_WIDTH  = 32;
    localparam int FFT4_HW     = FFT4_WIDTH / 2;
    localparam int FFT4_TW_ONE = 1;

    typedef enum logic [2:0] {
        LOAD,
        S1A,
        S1B,
        S2A,
        S2B,
        UNLOAD
    } fft4_state_e;

    function automatic logic [FFT4_WIDTH-1:0] cplx_pack(
        input logic signed [FFT4_HW-1:0] re,
        input logic signed [FFT4_HW-1:0] im
    );
        return {re, im};
    endfunction

    function automatic logic signed [FFT4_HW-1:0] cplx_re(
        input logic [FFT4_WIDTH-1:0] c
    );
        return c[FFT4_WIDTH-1:FFT4_HW];
    endfunction

    function automatic logic signed [FFT4_HW-1:0] cplx_im(
        input logic [FFT4_WIDTH-1:0] c
    );
        return c[FFT4_HW-1:0];
    endfunction

    localparam logic [FFT4_WIDTH-1:0] FFT4_W0 =
        {FFT4_HW'(FFT4_TW_ONE), FFT4_HW'(0)};
    localparam logic [FFT4_WIDTH-1:0] FFT4_W1_FWD =
        {FFT4_HW'(0), FFT4_HW'(-FFT4_TW_ONE)};
    localparam logic [FFT4_WIDTH-1:0] FFT4_W1_INV =
        {FFT4_HW'(0), FFT4_HW'(FFT4_TW_ONE)};

    // Bit-reversed storage: X0,X1,X2,X3 live in reg0,reg2,reg1,reg3
    localparam logic [7:0] FFT4_UNLOAD_ORDER = {2'd3, 2'd1, 2'd2, 2'd0};

endpackage

// File: rtl/fft4_twiddle_sel.sv
// Twiddle selection per compute state; W1 is -j, or +j for inverse frames
// when FFT4_INV_EN is defined.
module fft4_twiddle_sel
    import fft4_pkg::*;
#(
    parameter int WIDTH  = FFT4_WIDTH,
    parameter int TW_ONE = FFT4_TW_ONE
) (
    input  fft4_state_e        i_state,
`ifdef FFT4_INV_EN
    input  logic               i_inv,
`endif
    output logic [WIDTH-1:0]   o_w
);

    localparam int HW = WIDTH / 2;
    localparam logic [WIDTH-1:0] W0  = {HW'(TW_ONE), HW'(0)};
    localparam logic [WIDTH-1:0] W1F = {HW'(0), HW'(-TW_ONE)};
    localparam logic [WIDTH-1:0] W1I = {HW'(0), HW'(TW_ONE)};

    logic [WIDTH-1:0] w_w1;

`ifdef FFT4_INV_EN
    assign w_w1 = i_inv ? W1I : W1F;
`else
    assign w_w1 = W1F;
`endif

    always_comb begin
        o_w = '0;
        unique case (i_state)
            S1A, S1B, S2A: o_w = W0;
            S2B:           o_w = w_w1;
            default:       o_w = '0;
        endcase
    end

endmodule

// File: rtl/fft4_seq_ctrl.sv
// 4-point DIT FFT sequencer time-sharing one external radix-2 butterfly.
// Define FFT4_INV_EN to add the inv port for unscaled inverse transforms.
module fft4_seq_ctrl
    import fft4_pkg::*;
#(
    parameter int WIDTH  = FFT4_WIDTH,
    parameter int TW_ONE = FFT4_TW_ONE
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef FFT4_INV_EN
    input  logic             inv,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [WIDTH-1:0] bf_a,
    output logic [WIDTH-1:0] bf_b,
    output logic [WIDTH-1:0] bf_w,
    input  logic [WIDTH-1:0] bf_out0,
    input  logic [WIDTH-1:0] bf_out1
);

    fft4_state_e      r_state;
    fft4_state_e      w_next;
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_reg [4];
    logic [1:0]       w_ia;
    logic [1:0]       w_ib;
    logic             w_wr;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [1:0]       w_osel;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_osel     = FFT4_UNLOAD_ORDER[{r_cnt, 1'b0} +: 2];
    assign out_data   = r_reg[w_osel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        bf_a      = '0;
        bf_b      = '0;
        w_ia      = 2'd0;
        w_ib      = 2'd0;
        w_wr      = 1'b0;
        unique case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && r_cnt == 2'd3) w_next = S1A;
            end
            S1A: begin
                w_ia = 2'd0; w_ib = 2'd2; w_wr = 1'b1;
                w_next = S1B;
            end
            S1B: begin
                w_ia = 2'd1; w_ib = 2'd3; w_wr = 1'b1;
                w_next = S2A;
            end
            S2A: begin
                w_ia = 2'd0; w_ib = 2'd1; w_wr = 1'b1;
                w_next = S2B;
            end
            S2B: begin
                w_ia = 2'd2; w_ib = 2'd3; w_wr = 1'b1;
                w_next = UNLOAD;
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_last  = (r_cnt == 2'd3);
                if (out_ready && r_cnt == 2'd3) w_next = LOAD;
            end
            default: w_next = LOAD;
        endcase
        if (w_wr) begin
            bf_a = r_reg[w_ia];
            bf_b = r_reg[w_ib];
        end
    end

`ifdef FFT4_INV_EN
    logic r_inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv <= 1'b0;
        end else if (w_in_fire && r_cnt == 2'd0) begin
            r_inv <= inv;
        end
    end
`endif

    // r_cnt indexes the load slot, then the unload word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            for (int i = 0; i < 4; i++) r_reg[i] <= '0;
        end else begin
            if (w_in_fire) begin
                r_reg[r_cnt] <= in_data;
                r_cnt        <= r_cnt + 2'd1;
            end
            if (w_wr) begin
                r_reg[w_ia] <= bf_out0;
                r_reg[w_ib] <= bf_out1;
            end
            if (w_out_fire) r_cnt <= r_cnt + 2'd1;
        end
    end

    fft4_twiddle_sel #(
        .WIDTH  (WIDTH),
        .TW_ONE (TW_ONE)
    ) u_tw (
        .i_state (r_state),
`ifdef FFT4_INV_EN
        .i_inv   (r_inv),
`endif
        .o_w     (bf_w)
    );

endmodule

// File: tb/tb_fft4_seq_ctrl.sv
// Directed-vector bench for fft4_seq_ctrl with a behavioural butterfly.
// Inverse-mode frames are exercised when FFT4_INV_EN is defined.
module tb_fft4_seq_ctrl;
    import fft4_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic [31:0] bf_a, bf_b, bf_w, bf_out0, bf_out1;
`ifdef FFT4_INV_EN
    logic        inv = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fft4_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FFT4_INV_EN
        .inv       (inv),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .bf_a      (bf_a),
        .bf_b      (bf_b),
        .bf_w      (bf_w),
        .bf_out0   (bf_out0),
        .bf_out1   (bf_out1)
    );

    // Butterfly: out0 = A + B*W, out1 = A - B*W, half-word wrap
    logic signed [15:0] ar, ai, br, bi, wr, wi;
    int p_re, p_im;
    always_comb begin
        ar = cplx_re(bf_a); ai = cplx_im(bf_a);
        br = cplx_re(bf_b); bi = cplx_im(bf_b);
        wr = cplx_re(bf_w); wi = cplx_im(bf_w);
        p_re = int'(br) * int'(wr) - int'(bi) * int'(wi);
        p_im = int'(br) * int'(wi) + int'(bi) * int'(wr);
        bf_out0 = cplx_pack(ar + 16'(p_re), ai + 16'(p_im));
        bf_out1 = cplx_pack(ar - 16'(p_re), ai - 16'(p_im));
    end

    typedef struct packed {
        logic [3:0][31:0] x;
        logic [3:0][31:0] e;
        logic             gaps;
        logic             stall;
        logic             hold;
        logic             inv;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] x0, x1, x2, x3,
        input logic [31:0] e0, e1, e2, e3,
        input logic g, s, h, iv
    );
        vec_t v;
        v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        v.gaps = g; v.stall = s; v.hold = h; v.inv = iv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_samples(input vec_t v);
        int w;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (v.gaps && i[0]) begin
                in_valid = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
            end
`ifdef FFT4_INV_EN
            inv = (i == 0) ? v.inv : ~v.inv;
`endif
            in_valid = 1'b1;
            in_data  = v.x[i];
            w = 0;
            while (!in_ready && w < 20) begin
                @(posedge clk); #1; w++;
            end
            if (w == 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        if (v.hold) in_data = 32'hDEAD_BEEF;
        else in_valid = 1'b0;
    endtask

    task automatic finish_frame(input vec_t v, input string tag);
        int miss, k, cyc;
        logic rdy;
        logic [3:0] pat;
        logic [31:0] w1;
        pat  = 4'b1001;
        w1   = v.inv ? FFT4_W1_INV : FFT4_W1_FWD;
        miss = 0;
        @(negedge clk);
        while (!out_valid && miss < 20) begin
            chk({tag, "_in_ready_busy"}, 32'({in_ready, busy}), 32'd1);
            if (miss == 0) chk({tag, "_w_s1a"}, bf_w, FFT4_W0);
            if (miss == 3) chk({tag, "_w_s2b"}, bf_w, w1);
            miss++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(miss), 32'd4);
        in_valid = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 64) begin
            rdy = v.stall ? pat[cyc % 4] : 1'b1;
            out_ready = rdy;
            chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, $sformatf("_X%0d", k)}, out_data, v.e[k]);
            chk({tag, "_out_last"}, 32'(out_last), 32'(k == 3));
            cyc++;
            if (rdy) k++;
            if (k < 4) @(negedge clk);
        end
        if (k < 4) chk({tag, "_unload_timeout"}, 32'(k), 32'd4);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_back_to_load"},
            32'({out_valid, in_ready, busy}), 32'b010);
    endtask

    vec_t vecs[7];
    vec_t imp;

    initial begin
        imp = mk(32'h00010000, 0, 0, 0,
                 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000,
                 0, 0, 0, 0);
        vecs[0] = imp;
        vecs[1] = mk(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000,
                     32'h00040000, 0, 0, 0, 0, 0, 0, 0);
        vecs[2] = mk(0, 32'h00010000, 0, 0,
                     32'h00010000, 32'h0000FFFF, 32'hFFFF0000, 32'h00000001,
                     0, 1, 0, 0);
        vecs[3] = mk(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000,
                     32'h000A0000, 32'hFFFE0002, 32'hFFFE0000, 32'hFFFEFFFE,
                     1, 0, 0, 0);
        vecs[4] = mk(32'h00000001, 0, 0, 0,
                     32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001,
                     0, 0, 1, 0);
        vecs[5] = mk(32'h7FFF0000, 32'h7FFF0000, 0, 0,
                     32'hFFFE0000, 32'h7FFF8001, 32'h00000000, 32'h7FFF7FFF,
                     0, 0, 0, 0);
        vecs[6] = mk(0, 32'h00010000, 0, 0,
                     32'h00010000, 32'h0000FFFF, 32'hFFFF0000, 32'h00000001,
                     1, 1, 0, 0);

        #12;
        chk("rst_ctrl", 32'({in_ready, out_valid, out_last, busy}), 32'b1000);
        chk("rst_bf_a", bf_a, 32'd0);
        chk("rst_bf_b", bf_b, 32'd0);
        chk("rst_bf_w", bf_w, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send_samples(vecs[i]);
            finish_frame(vecs[i], $sformatf("v%0d", i));
        end

        // Reset asserted while in S2A
        send_samples(imp);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_async", 32'({in_ready, out_valid, busy}), 32'b100);
        chk("midrst_bf_a", bf_a, 32'd0);
        chk("midrst_bf_w", bf_w, 32'd0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_next", 32'({in_ready, out_valid, busy}), 32'b100);
        send_samples(imp);
        finish_frame(imp, "post_rst");

`ifdef FFT4_INV_EN
        send_samples(mk(0, 32'h00010000, 0, 0,
                        32'h00010000, 32'h00000001, 32'hFFFF0000, 32'h0000FFFF,
                        0, 0, 0, 1));
        finish_frame(mk(0, 32'h00010000, 0, 0,
                        32'h00010000, 32'h00000001, 32'hFFFF0000, 32'h0000FFFF,
                        0, 0, 0, 1), "inv1");
        send_samples(vecs[2]);
        finish_frame(vecs[2], "inv0");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
